// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared memory constants: default geometry used by both the FIFO front end
// and the single-port RAM, so both are instantiated from the same values.
package ram_fifo_ctrl_pkg;

  localparam int unsigned MemDataWidth = 8;
  localparam int unsigned MemAddrWidth = 3;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a valid/ready write stream and a valid/ready read stream
// into one-access-per-cycle commands for a single-port synchronous RAM, so the
// RAM behaves as a FIFO. One output register holds the word presented on m_*.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   write stream
//   m_valid/m_ready/m_data   read stream
//   ram_en/ram_we/ram_addr/ram_din   RAM command; ram_dout valid cycle after read
//   count/full/empty   occupancy status (count and full cover the RAM only)
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MemDataWidth,
  parameter int unsigned ADDR_WIDTH = MemAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic rd_go;
  logic wr_go;
  logic out_free;

  // Output register is free if empty or being consumed at this edge.
  assign out_free = !m_valid_q || m_ready;
  // rd_pend blocks back-to-back reads, which guarantees a write slot every
  // other cycle.
  assign rd_go    = (count_q != '0) && !rd_pend_q && out_free;
  assign full     = (count_q == {1'b1, {ADDR_WIDTH{1'b0}}});
  // Reads win the single port.
  assign s_ready  = !full && !rd_go;
  assign wr_go    = s_valid && s_ready;

  always_comb begin
    ram_en   = rd_go || wr_go;
    ram_we   = wr_go;
    ram_addr = rd_go ? rd_ptr_q : wr_ptr_q;
    ram_din  = s_data;
  end

  always_comb begin
    wr_ptr_d  = wr_go ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = rd_go ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + {{ADDR_WIDTH{1'b0}}, wr_go} - {{ADDR_WIDTH{1'b0}}, rd_go};
    rd_pend_d = rd_go;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    // A completing read overrides the consume-clear.
    if (rd_pend_q) begin
      m_valid_d = 1'b1;
      m_data_d  = ram_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign count   = count_q;
  assign empty   = (count_q == '0) && !rd_pend_q && !m_valid_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural single-port synchronous RAM.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       ram_en;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_q[$];
  logic [2:0] exp_wa = 3'd0;
  logic [2:0] exp_ra = 3'd0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  bit         done   = 1'b0;

  logic [7:0] mem [8];
  logic [7:0] dout_q;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      dout_q <= mem[ram_addr];
    end
  end
  assign ram_dout = dout_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write-side observer: every accepted word is expected on the read side.
  always @(negedge clk) begin
    if (!rst && s_valid && s_ready) exp_q.push_back(s_data);
  end

  // Read-side monitor and RAM command checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_v && m_valid) check("m_data_hold", {24'd0, m_data}, {24'd0, hold_d});
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, m_data}, 32'hffff_ffff);
        end else begin
          check("m_data_order", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (ram_en && ram_we) begin
        check("wr_addr", {29'd0, ram_addr}, {29'd0, exp_wa});
        check("wr_din", {24'd0, ram_din}, {24'd0, s_data});
        exp_wa = exp_wa + 3'd1;
      end else if (ram_en) begin
        check("rd_addr", {29'd0, ram_addr}, {29'd0, exp_ra});
        check("rd_blocks_wr", {31'd0, s_ready}, 32'd0);
        exp_ra = exp_ra + 3'd1;
      end
    end
  end

  task automatic flush_model();
    exp_q.delete();
    exp_wa = 3'd0;
    exp_ra = 3'd0;
    hold_v = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (empty) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_empty", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset
    #1 rst = 1'b1;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    rst = 1'b0;
    #1;
    check("init_s_ready", {31'd0, s_ready}, 32'd1);
    check("init_m_valid", {31'd0, m_valid}, 32'd0);
    check("init_empty", {31'd0, empty}, 32'd1);
    check("init_full", {31'd0, full}, 32'd0);
    check("init_count", {28'd0, count}, 32'd0);
    check("init_ram_en", {31'd0, ram_en}, 32'd0);
    check("init_m_data", {24'd0, m_data}, 32'd0);
    @(posedge clk);
    #1;

    // 2: prefetch of first word, three left in RAM
    m_ready = 1'b0;
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    push(8'hDD);
    s_valid = 1'b0;
    check("t2_m_valid", {31'd0, m_valid}, 32'd1);
    check("t2_m_data", {24'd0, m_data}, 32'h0000_00AA);
    check("t2_count", {28'd0, count}, 32'd3);
    m_ready = 1'b1;
    wait_empty();

    // 3: fill to capacity (8 in RAM + 1 in output register)
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i));
    s_data = 8'h0A;
    repeat (4) @(posedge clk);
    #1;
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_count", {28'd0, count}, 32'd8);
    check("t3_s_ready", {31'd0, s_ready}, 32'd0);
    check("t3_m_data", {24'd0, m_data}, 32'h0000_0001);
    check("t3_not_empty", {31'd0, empty}, 32'd0);
    m_ready = 1'b1;
    push(8'h0A);
    s_valid = 1'b0;
    wait_empty();

    // 4: streaming with m_ready toggling every cycle, pointers wrap
    m_ready = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 8'h10; i <= 8'h23; i++) push(8'(i));
        s_valid = 1'b0;
        wait_empty();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (!done) m_ready = ~m_ready;
        end
      end
    join
    m_ready = 1'b1;

    // 5: read beats a simultaneous write; 34 words so far, so both ptrs = 2
    s_valid = 1'b1;
    s_data  = 8'h30;
    @(negedge clk);
    check("t5_wr0_we", {31'd0, ram_we}, 32'd1);
    check("t5_wr0_addr", {29'd0, ram_addr}, 32'd2);
    @(posedge clk);
    #1;
    s_data = 8'h31;
    @(negedge clk);
    check("t5_rd_en", {31'd0, ram_en}, 32'd1);
    check("t5_rd_we", {31'd0, ram_we}, 32'd0);
    check("t5_rd_addr", {29'd0, ram_addr}, 32'd2);
    check("t5_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_wr1_we", {31'd0, ram_we}, 32'd1);
    check("t5_wr1_addr", {29'd0, ram_addr}, 32'd3);
    check("t5_wr1_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    wait_empty();

    // 6: asynchronous reset with a read in flight and 5 words in RAM
    m_ready = 1'b0;
    for (int i = 8'h40; i <= 8'h46; i++) push(8'(i));
    s_valid = 1'b0;
    check("t6_count6", {28'd0, count}, 32'd6);
    check("t6_m_data", {24'd0, m_data}, 32'h0000_0040);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_count5", {28'd0, count}, 32'd5);
    #2 rst = 1'b1;
    flush_model();
    #1;
    check("t6_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("t6_rst_count", {28'd0, count}, 32'd0);
    check("t6_rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("t6_rst_empty", {31'd0, empty}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    @(negedge clk);
    check("t6_wr_we", {31'd0, ram_we}, 32'd1);
    check("t6_wr_addr", {29'd0, ram_addr}, 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    wait_empty();
    check("t6_last_m_data", {24'd0, m_data}, 32'h0000_0055);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
